// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: the fetch stage and the LSU share one downstream port.
// There is at most one transaction in flight, and its response is routed back to the owner.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic grant_ifu;
  logic grant_lsu;
  logic owner_resp_ready;
  logic in_resp;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    grant_ifu    = 1'b0;
    grant_lsu    = 1'b0;

    owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    case (state_q)
      S_IDLE: begin
        // On a tie the LSU wins, unless round-robin is enabled and the LSU was the last owner.
        if (lsu_req_valid && (!ifu_req_valid || !RR_EN || (last_owner_q == OWN_IFU))) begin
          grant_lsu = 1'b1;
          owner_d   = OWN_LSU;
          addr_d    = lsu_req_addr;
          wen_d     = lsu_req_wen;
          wdata_d   = lsu_req_wdata;
          wstrb_d   = lsu_req_wstrb;
          state_d   = S_REQ;
        end else if (ifu_req_valid) begin
          grant_ifu = 1'b1;
          owner_d   = OWN_IFU;
          addr_d    = ifu_req_addr;
          wen_d     = 1'b0;
          wdata_d   = '0;
          wstrb_d   = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d      = S_RESP;
          last_owner_d = owner_q;
        end
      end
      S_RESP: begin
        if (mem_resp_valid && owner_resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are held low while reset is asserted, so an abandoned transaction never leaks a response.
  assign in_resp        = !rst && (state_q == S_RESP);
  assign ifu_req_ready  = !rst && grant_ifu;
  assign lsu_req_ready  = !rst && grant_lsu;
  assign mem_req_valid  = !rst && (state_q == S_REQ);
  assign mem_resp_ready = in_resp && owner_resp_ready;
  assign ifu_resp_valid = in_resp && (owner_q == OWN_IFU) && mem_resp_valid;
  assign lsu_resp_valid = in_resp && (owner_q == OWN_LSU) && mem_resp_valid;
  assign ifu_resp_rdata = (in_resp && (owner_q == OWN_IFU)) ? mem_resp_rdata : '0;
  assign lsu_resp_rdata = (in_resp && (owner_q == OWN_LSU)) ? mem_resp_rdata : '0;

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: idle-grant table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, lsu_req_valid, lsu_req_wen;
  logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata, mem_resp_rdata;
  logic [3:0]  lsu_req_wstrb;
  logic        ifu_resp_ready, lsu_resp_ready, mem_req_ready, mem_resp_valid;

  logic        ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid;
  logic [31:0] ifu_resp_rdata, lsu_resp_rdata;
  logic        mem_req_valid, mem_req_wen, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;

  logic        fp_ifu_req_ready, fp_lsu_req_ready, fp_ifu_resp_valid, fp_lsu_resp_valid;
  logic [31:0] fp_ifu_resp_rdata, fp_lsu_resp_rdata;
  logic        fp_mem_req_valid, fp_mem_req_wen, fp_mem_resp_ready;
  logic [31:0] fp_mem_req_addr, fp_mem_req_wdata;
  logic [3:0]  fp_mem_req_wstrb;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(fp_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(fp_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(fp_ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(fp_lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(fp_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(fp_lsu_resp_rdata),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(fp_mem_req_addr),
    .mem_req_wen(fp_mem_req_wen), .mem_req_wdata(fp_mem_req_wdata), .mem_req_wstrb(fp_mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(fp_mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic lv,
                               input logic lw, input logic [31:0] la, input logic [31:0] ld,
                               input logic [3:0] ls);
    ifu_req_valid = iv; ifu_req_addr = ia;
    lsu_req_valid = lv; lsu_req_wen = lw; lsu_req_addr = la;
    lsu_req_wdata = ld; lsu_req_wstrb = ls;
  endtask

  task automatic resetDut();
    nextCycle();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ifu_resp_ready = 0; lsu_resp_ready = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = 0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Reference model: tracks one pending transaction as a record plus a "sent downstream" flag.
  bit          m_busy, m_sent, m_lsu, m_last_lsu;
  logic [68:0] m_fields;

  always @(negedge clk) begin : model
    logic g_lsu, g_ifu, own_rr;
    logic [5:0] exp_hs;
    if (rst) begin
      checkOutput("reset_outputs_low",
                  {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, 0);
      m_busy = 0; m_sent = 0; m_last_lsu = 0;
    end else begin
      g_lsu  = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
      g_ifu  = !m_busy && ifu_req_valid && !g_lsu;
      own_rr = m_lsu ? lsu_resp_ready : ifu_resp_ready;
      exp_hs = {g_ifu, g_lsu, m_busy && !m_sent, m_busy && m_sent && own_rr,
                m_busy && m_sent && !m_lsu && mem_resp_valid, m_busy && m_sent && m_lsu && mem_resp_valid};
      checkOutput("model_handshakes",
                  {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, exp_hs);
      if (m_busy && !m_sent)
        checkOutput("model_mem_req_fields", {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}, m_fields);
      if (m_busy && m_sent && mem_resp_valid)
        checkOutput("model_resp_rdata", m_lsu ? lsu_resp_rdata : ifu_resp_rdata, mem_resp_rdata);
      if (g_lsu) begin
        m_busy = 1; m_sent = 0; m_lsu = 1; m_last_lsu = 1;
        m_fields = {lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb};
      end else if (g_ifu) begin
        m_busy = 1; m_sent = 0; m_lsu = 0; m_last_lsu = 0;
        m_fields = {ifu_req_addr, 1'b0, 32'h0, 4'h0};
      end else if (m_busy && !m_sent && mem_req_ready) begin
        m_sent = 1;
      end else if (m_busy && m_sent && mem_resp_valid && own_rr) begin
        m_busy = 0;
        done_cnt++;
      end
    end
  end

  typedef struct {
    logic ifu_v;
    logic lsu_v;
    logic exp_ifu_rdy;
    logic exp_lsu_rdy;
  } idle_vec_t;

  idle_vec_t idle_tbl[4];

  initial begin
    logic lsu_seen;
    int   delivered;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ifu_resp_ready = 0; lsu_resp_ready = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = 0;

    idle_tbl[0] = '{0, 0, 0, 0};
    idle_tbl[1] = '{1, 0, 1, 0};
    idle_tbl[2] = '{0, 1, 0, 1};
    idle_tbl[3] = '{1, 1, 0, 1};

    resetDut();
    nextCycle();
    checkOutput("reset_latched_fields", {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}, 0);
    // Combinational idle grants, probed within one cycle; valids drop before the next edge.
    for (int i = 0; i < 4; i++) begin
      ifu_req_valid = idle_tbl[i].ifu_v;
      lsu_req_valid = idle_tbl[i].lsu_v;
      #1;
      checkOutput($sformatf("idle_tbl_rr_%0d", i), {ifu_req_ready, lsu_req_ready},
                  {idle_tbl[i].exp_ifu_rdy, idle_tbl[i].exp_lsu_rdy});
      checkOutput($sformatf("idle_tbl_fp_%0d", i), {fp_ifu_req_ready, fp_lsu_req_ready},
                  {idle_tbl[i].exp_ifu_rdy, idle_tbl[i].exp_lsu_rdy});
      #1;
    end
    ifu_req_valid = 0; lsu_req_valid = 0;

    // IFU alone, two wait cycles before the read data.
    resetDut();
    lsu_seen = 0;
    nextCycle();
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
    ifu_resp_ready = 1;
    @(negedge clk);
    checkOutput("t1_ifu_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    nextCycle();
    ifu_req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    checkOutput("t1_mem_req", {mem_req_valid, mem_req_addr, mem_req_wen}, {1'b1, 32'h8000_0000, 1'b0});
    for (int w = 0; w < 2; w++) begin
      nextCycle();
      mem_req_ready = 0;
      @(negedge clk);
      checkOutput("t1_wait_no_resp", ifu_resp_valid, 0);
      lsu_seen |= lsu_resp_valid;
    end
    nextCycle();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    @(negedge clk);
    checkOutput("t1_ifu_resp", {ifu_resp_valid, ifu_resp_rdata}, {1'b1, 32'h0000_0413});
    lsu_seen |= lsu_resp_valid;
    nextCycle();
    mem_resp_valid = 0;
    @(negedge clk);
    lsu_seen |= lsu_resp_valid;
    checkOutput("t1_lsu_resp_never", lsu_seen, 0);

    // Continuous tie: RR instance alternates LSU/IFU, fixed-priority instance always picks the LSU.
    resetDut();
    nextCycle();
    applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 0);
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h55;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        checkOutput($sformatf("t2_rr_grant_%0d", c / 3), {ifu_req_ready, lsu_req_ready},
                    ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
        checkOutput($sformatf("t3_fp_grant_%0d", c / 3), {fp_ifu_req_ready, fp_lsu_req_ready}, 2'b01);
      end else begin
        checkOutput("t2_busy_no_grant", {ifu_req_ready, lsu_req_ready, fp_ifu_req_ready, fp_lsu_req_ready}, 0);
      end
      nextCycle();
    end

    // LSU write with downstream backpressure; request inputs change after the grant.
    resetDut();
    nextCycle();
    applyStimulus(0, 0, 1, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    checkOutput("t4_lsu_grant", lsu_req_ready, 1);
    for (int w = 0; w < 5; w++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 32'h1111_2222, 32'h3333_4444, 4'b1100);
      mem_req_ready = (w == 4);
      @(negedge clk);
      checkOutput($sformatf("t4_mem_req_%0d", w),
                  {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb},
                  {1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    end
    nextCycle();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234; lsu_resp_ready = 1;
    @(negedge clk);
    checkOutput("t4_write_resp", {lsu_resp_valid, ifu_resp_valid, mem_resp_ready}, 3'b101);

    // Owner stalls the response; no new grant until it is taken.
    resetDut();
    delivered = 0;
    nextCycle();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    mem_req_ready = 1;
    @(negedge clk);
    checkOutput("t5_ifu_grant", ifu_req_ready, 1);
    nextCycle();
    ifu_req_valid = 0;
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      lsu_req_valid = 1; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_0001;
      ifu_resp_ready = (c >= 3);
      @(negedge clk);
      if (ifu_resp_valid && ifu_resp_ready) delivered++;
      if (c < 3)
        checkOutput("t5_stall", {mem_resp_ready, ifu_resp_valid, lsu_req_ready}, 3'b010);
      else if (c == 3)
        checkOutput("t5_release", {mem_resp_ready, ifu_resp_valid, lsu_req_ready}, 3'b110);
      else
        checkOutput("t5_regrant", {ifu_resp_valid, lsu_req_ready}, 2'b01);
    end
    checkOutput("t5_delivered_once", delivered, 1);

    // Reset while waiting for the response.
    resetDut();
    nextCycle();
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0);
    mem_req_ready = 1; ifu_resp_ready = 1;
    nextCycle();
    ifu_req_valid = 0;
    nextCycle();
    @(negedge clk);
    checkOutput("t6_in_resp", {mem_resp_ready, ifu_resp_valid}, 2'b10);
    nextCycle();
    rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h77;
    @(negedge clk);
    checkOutput("t6_rst_no_resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 0);
    nextCycle();
    rst = 0; ifu_req_valid = 1; ifu_req_addr = 32'h90;
    @(negedge clk);
    checkOutput("t6_after_rst", {ifu_req_ready, ifu_resp_valid, mem_resp_ready, mem_req_valid}, 4'b1000);
    checkOutput("t6_fields_cleared", mem_req_addr, 0);

    // Randomized traffic, checked by the reference model.
    resetDut();
    done_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      applyStimulus($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom, $urandom, 4'($urandom));
      ifu_resp_ready = $urandom_range(0, 1);
      lsu_resp_ready = $urandom_range(0, 1);
      mem_req_ready  = $urandom_range(0, 1);
      mem_resp_valid = $urandom_range(0, 1);
      mem_resp_rdata = $urandom;
    end
    nextCycle();
    checkOutput("random_progress", done_cnt > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
